mult_ctrl: RTL and testbench

MULT_CTRL -- requirements
Module: mult_ctrl

---
 rtl/mult_ctrl.sv | 118 +++++++++++
 tb/tb_mult_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencer for a shift-and-add multiplier (LOAD -> RUN x WIDTH -> FLUSH -> DONE).
// Latency: start sampled at edge 0, load_en in cycle 1, done in cycle WIDTH+3 (earlier with early exit).
// Flow control: start is only sampled in IDLE; abort cancels LOAD/RUN/FLUSH; optional early exit via `MULT_CTRL_EARLY_EXIT_EN.
module mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         b_zero,
  output logic                         load_en,
  output logic                         acc_clr,
  output logic                         shift,
  output logic                         acc_add,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   iter
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] ITER_MAX  = IW'(WIDTH);
  localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [IW-1:0] r_iter;
  logic          r_acc_add;
  logic          w_early_exit;

  // Early exit only once at least one shift has landed, so a freshly loaded
  // B register cannot end the run before it has been looked at.
`ifdef MULT_CTRL_EARLY_EXIT_EN
  assign w_early_exit = b_zero && (r_iter != '0);
`else
  logic w_unused_b_zero;
  assign w_unused_b_zero = b_zero;
  assign w_early_exit    = 1'b0;
`endif

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort wins over normal progress in LOAD/RUN/FLUSH
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if ((r_iter >= ITER_LAST) || w_early_exit) begin
          w_next_state = S_FLUSH;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_FLUSH: w_next_state = abort ? S_IDLE : S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the registered state only; busy covers DONE as well
  always_comb begin
    load_en = 1'b0;
    acc_clr = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_LOAD:  begin load_en = 1'b1; acc_clr = 1'b1; busy = 1'b1; end
      S_RUN:   begin shift = 1'b1; busy = 1'b1; end
      S_FLUSH: busy = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Shift counter: cleared on entry to LOAD, counts each RUN cycle, saturates at WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iter <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_iter <= '0;
    end else if ((r_state == S_RUN) && (r_iter != ITER_MAX)) begin
      r_iter <= r_iter + 1'b1;
    end
  end

  // acc_add trails shift by one cycle (B's serial bit is registered); an abort kills it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_add <= 1'b0;
    end else begin
      r_acc_add <= (r_state == S_RUN) && !abort;
    end
  end

  assign acc_add = r_acc_add;
  assign iter    = r_iter;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed vector table plus hand-written back-to-back and early-exit sequences.
// Each vector's inputs are applied for one cycle; outputs are compared 1 time unit after the edge.
// Expected values are hand-computed for WIDTH=4.
module tb_mult_ctrl;

  localparam int W  = 4;
  localparam int IW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst, start, abort, b_zero;
  logic          load_en, acc_clr, shift, acc_add, busy, done;
  logic [IW-1:0] iter;

  int n_checks = 0;
  int n_errors = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .b_zero  (b_zero),
    .load_en (load_en),
    .acc_clr (acc_clr),
    .shift   (shift),
    .acc_add (acc_add),
    .busy    (busy),
    .done    (done),
    .iter    (iter)
  );

  always #5 clk = ~clk;

  // exp bit order: {load_en, acc_clr, shift, acc_add, busy, done}
  typedef struct {
    logic       r;
    logic       s;
    logic       a;
    logic       z;
    logic [5:0] exp;
    int         it;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic a, input logic z,
                     input logic [5:0] e, input int it);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.z = z; v.exp = e; v.it = it;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int shifts;
    int done_cyc;
    int done_iter;

    // reset
    add(1,0,0,0, 6'b000000, 0);
    // normal operation: LOAD, RUN x4, FLUSH, DONE, IDLE
    add(0,1,0,0, 6'b110010, 0);
    add(0,0,0,0, 6'b001010, 0);
    add(0,0,0,0, 6'b001110, 1);
    add(0,0,0,0, 6'b001110, 2);
    add(0,0,0,0, 6'b001110, 3);
    add(0,0,0,0, 6'b000110, 4);
    add(0,0,0,0, 6'b000011, 4);
    add(0,0,0,0, 6'b000000, 4);
    // abort in the 2nd RUN cycle, then abort in IDLE has no effect
    add(0,1,0,0, 6'b110010, 0);
    add(0,0,0,0, 6'b001010, 0);
    add(0,0,0,0, 6'b001110, 1);
    add(0,0,1,0, 6'b000000, 2);
    add(0,0,1,0, 6'b000000, 2);
    // new start accepted, abort in LOAD
    add(0,1,0,0, 6'b110010, 0);
    add(0,0,1,0, 6'b000000, 0);
    // start+abort in IDLE enters LOAD; start ignored while running; start+abort in DONE ignored
    add(0,1,1,0, 6'b110010, 0);
    add(0,1,0,0, 6'b001010, 0);
    add(0,1,0,0, 6'b001110, 1);
    add(0,1,0,0, 6'b001110, 2);
    add(0,1,0,0, 6'b001110, 3);
    add(0,1,0,0, 6'b000110, 4);
    add(0,1,0,0, 6'b000011, 4);
    add(0,1,1,0, 6'b000000, 4);
    // reset in the 3rd RUN cycle overrides start/abort; start accepted right after
    add(0,1,0,0, 6'b110010, 0);
    add(0,0,0,0, 6'b001010, 0);
    add(0,0,0,0, 6'b001110, 1);
    add(0,0,0,0, 6'b001110, 2);
    add(1,1,1,0, 6'b000000, 0);
    add(0,1,0,0, 6'b110010, 0);
    // run to FLUSH, then abort in FLUSH: no DONE, no acc_add, iter held
    add(0,0,0,0, 6'b001010, 0);
    add(0,0,0,0, 6'b001110, 1);
    add(0,0,0,0, 6'b001110, 2);
    add(0,0,0,0, 6'b001110, 3);
    add(0,0,0,0, 6'b000110, 4);
    add(0,0,1,0, 6'b000000, 4);
    add(0,0,0,0, 6'b000000, 4);

    foreach (vecs[i]) begin
      rst = vecs[i].r; start = vecs[i].s; abort = vecs[i].a; b_zero = vecs[i].z;
      tick();
      chk($sformatf("vec%0d_outs", i),
          int'({load_en, acc_clr, shift, acc_add, busy, done}), int'(vecs[i].exp));
      chk($sformatf("vec%0d_iter", i), int'(iter), vecs[i].it);
    end

    // start held high: LOAD every 8 cycles, one IDLE cycle between done and load_en
    rst = 0; abort = 0; b_zero = 0; start = 1;
    for (c = 1; c <= 24; c++) begin
      tick();
      chk($sformatf("b2b_c%0d_load", c), int'(load_en), int'((c % 8) == 1));
      chk($sformatf("b2b_c%0d_done", c), int'(done),    int'((c % 8) == 7));
    end
    start = 0;
    tick();
    chk("b2b_idle_after", int'(busy), 0);

    // B = 0011: B register becomes zero once the 2nd shift lands
    start = 1;
    shifts = 0; done_cyc = -1; done_iter = -1;
    for (c = 1; c <= 20; c++) begin
      tick();
      start = 0;
      if (shift) shifts++;
      if (c == 3) b_zero = 1;
      if (done) begin
        done_cyc = c;
        done_iter = int'(iter);
        break;
      end
    end
    b_zero = 0;
`ifdef MULT_CTRL_EARLY_EXIT_EN
    chk("early_shifts",   shifts,    2);
    chk("early_done_cyc", done_cyc,  5);
    chk("early_iter",     done_iter, 2);
`else
    chk("noexit_shifts",   shifts,    4);
    chk("noexit_done_cyc", done_cyc,  7);
    chk("noexit_iter",     done_iter, 4);
`endif
    tick();
    chk("final_idle", int'({load_en, acc_clr, shift, acc_add, busy, done}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
